// File: rtl/jtag_tap_master.sv
// jtag_tap_master
//   On-chip JTAG master for the tap_top TAP. Runs on the system clock and builds
//   TCK/TMS/TDI from a programmable divider. One command at a time: an IR value
//   plus a DR bit count. It walks the TAP through IR (and optionally DR) scans and
//   streams DR data in (din) and captured TDO data out (dout).
//
//   Ports
//     clk_i, rst_i                 system clock, synchronous active-high reset
//     cmd_valid_i/cmd_ready_o      command handshake (ready only in Run-Test/Idle)
//     cmd_ir_i, cmd_len_i          instruction (LSB first), DR length (0 = IR only)
//     din_i/din_valid_i/din_ready_o  DR data words, LSB shifted first
//     dout_o/dout_valid_o          captured TDO words, strobe with no backpressure
//     done_o                       strobe when a command returns to Run-Test/Idle
//     tck_o, tms_o, tdi_o, tdo_i   JTAG pins towards tap_top
//     tap_rst_no                   TAP reset, registered ~rst_i
module jtag_tap_master #(
    parameter int IR_W    = 6,
    parameter int LEN_W   = 16,
    parameter int DATA_W  = 8,
    parameter int TCK_DIV = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [IR_W-1:0]   cmd_ir_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              din_valid_i,
    output logic              din_ready_o,
    output logic [DATA_W-1:0] dout_o,
    output logic              dout_valid_o,
    output logic              done_o,
    output logic              tck_o,
    output logic              tms_o,
    output logic              tdi_o,
    input  logic              tdo_i,
    output logic              tap_rst_no
);

    localparam int DIV_W  = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int STEP_W = $clog2(IR_W + 8);

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TCK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic [STEP_W-1:0] IR_LAST  = STEP_W'(IR_W - 1);

    typedef enum logic [3:0] {
        S_TLR, S_IDLE, S_IR_HDR, S_IR_SHIFT, S_IR_TAIL,
        S_IDLE_TAIL, S_DR_HDR, S_DR_SHIFT, S_DR_TAIL
    } state_t;

    state_t              state;
    logic [STEP_W-1:0]   step;        // period index within the current state
    logic [DIV_W-1:0]    div;
    logic                stall;       // waiting for a din word before a DR period
    logic [IR_W-1:0]     ir_sh;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    shift_left;  // DR periods not yet started
    logic [LEN_W-1:0]    load_left;   // DR bits not yet loaded from din
    logic [DATA_W-1:0]   hold;
    logic                full;
    logic [IDX_W-1:0]    bit_idx;
    logic [DATA_W-1:0]   obuf;
    logic [IDX_W-1:0]    cap_idx;

    logic                running, last_div, period_end, capture;
    logic                din_take, avail, start_req;
    logic [DATA_W-1:0]   word, cap_word;

    assign din_ready_o = !full && (state == S_DR_HDR || state == S_DR_SHIFT) && (load_left != '0);

    assign running    = (state != S_IDLE) && !stall;
    assign last_div   = (div == DIV_LAST);
    assign period_end = running && tck_o && last_div;
    // First high cycle of a DR shift period: the cycle in which TCK rose.
    assign capture    = running && (state == S_DR_SHIFT) && tck_o && (div == '0);
    assign din_take   = din_valid_i && din_ready_o;
    // A word arriving this cycle can feed a period starting this cycle.
    assign avail      = full || din_take;
    assign word       = full ? hold : din_i;
    assign cap_word   = obuf | (DATA_W'(tdo_i) << cap_idx);
    assign start_req  = stall ||
                        (period_end && ((state == S_DR_HDR && step == STEP_W'(2)) ||
                                        (state == S_DR_SHIFT && shift_left != '0)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= S_TLR;
            step         <= '0;
            div          <= '0;
            stall        <= 1'b0;
            ir_sh        <= '0;
            len_q        <= '0;
            shift_left   <= '0;
            load_left    <= '0;
            hold         <= '0;
            full         <= 1'b0;
            bit_idx      <= '0;
            obuf         <= '0;
            cap_idx      <= '0;
            tck_o        <= 1'b0;
            tms_o        <= 1'b1;
            tdi_o        <= 1'b0;
            tap_rst_no   <= 1'b0;
            cmd_ready_o  <= 1'b0;
            dout_o       <= '0;
            dout_valid_o <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            tap_rst_no   <= 1'b1;
            done_o       <= 1'b0;
            dout_valid_o <= 1'b0;

            if (din_take) begin
                hold      <= din_i;
                full      <= 1'b1;
                load_left <= (load_left > LEN_W'(DATA_W)) ? load_left - LEN_W'(DATA_W) : '0;
            end

            if (running) begin
                if (!last_div) begin
                    div <= div + 1'b1;
                end else if (!tck_o) begin
                    tck_o <= 1'b1;
                    div   <= '0;
                end else begin
                    // End of a bit period: TCK falls and the next TMS/TDI go out.
                    tck_o <= 1'b0;
                    div   <= '0;
                    case (state)
                        S_TLR: begin
                            if (step == STEP_W'(5)) begin
                                state       <= S_IDLE;
                                step        <= '0;
                                cmd_ready_o <= 1'b1;
                            end else begin
                                step  <= step + 1'b1;
                                tms_o <= (step < STEP_W'(4));
                            end
                        end
                        S_IR_HDR: begin
                            if (step == STEP_W'(3)) begin
                                state <= S_IR_SHIFT;
                                step  <= '0;
                                tms_o <= (IR_W == 1);
                                tdi_o <= ir_sh[0];
                                ir_sh <= ir_sh >> 1;
                            end else begin
                                step  <= step + 1'b1;
                                tms_o <= (step == '0);
                            end
                        end
                        S_IR_SHIFT: begin
                            if (step == IR_LAST) begin
                                state <= S_IR_TAIL;
                                tms_o <= 1'b1;
                                tdi_o <= 1'b0;
                            end else begin
                                step  <= step + 1'b1;
                                tms_o <= ((step + STEP_W'(1)) == IR_LAST);
                                tdi_o <= ir_sh[0];
                                ir_sh <= ir_sh >> 1;
                            end
                        end
                        S_IR_TAIL: begin
                            step <= '0;
                            if (len_q == '0) begin
                                state <= S_IDLE_TAIL;
                                tms_o <= 1'b0;
                            end else begin
                                state <= S_DR_HDR;
                                tms_o <= 1'b1;
                            end
                        end
                        S_DR_HDR: begin
                            // Last header period hands over to start_req below.
                            if (step != STEP_W'(2)) begin
                                step  <= step + 1'b1;
                                tms_o <= 1'b0;
                            end
                        end
                        S_DR_SHIFT: begin
                            if (shift_left == '0) begin
                                state <= S_DR_TAIL;
                                step  <= '0;
                                tms_o <= 1'b1;
                                tdi_o <= 1'b0;
                            end
                        end
                        S_DR_TAIL: begin
                            if (step == '0) begin
                                step  <= step + 1'b1;
                                tms_o <= 1'b0;
                            end else begin
                                state       <= S_IDLE;
                                done_o      <= 1'b1;
                                cmd_ready_o <= 1'b1;
                            end
                        end
                        S_IDLE_TAIL: begin
                            state       <= S_IDLE;
                            done_o      <= 1'b1;
                            cmd_ready_o <= 1'b1;
                        end
                        default: state <= S_TLR;
                    endcase
                end
            end

            if (state == S_IDLE && cmd_valid_i && cmd_ready_o) begin
                cmd_ready_o <= 1'b0;
                state       <= S_IR_HDR;
                step        <= '0;
                ir_sh       <= cmd_ir_i;
                len_q       <= cmd_len_i;
                shift_left  <= cmd_len_i;
                load_left   <= cmd_len_i;
                full        <= 1'b0;
                bit_idx     <= '0;
                obuf        <= '0;
                cap_idx     <= '0;
                tms_o       <= 1'b1;
                tdi_o       <= 1'b0;
                tck_o       <= 1'b0;
                div         <= '0;
            end

            if (capture) begin
                if (cap_idx == IDX_LAST || shift_left == '0) begin
                    dout_o       <= cap_word;
                    dout_valid_o <= 1'b1;
                    obuf         <= '0;
                    cap_idx      <= '0;
                end else begin
                    obuf    <= cap_word;
                    cap_idx <= cap_idx + 1'b1;
                end
            end

            // A DR shift period only starts with its data bit in hand; otherwise
            // TCK parks low with TMS/TDI held and the divider frozen.
            if (start_req) begin
                state <= S_DR_SHIFT;
                tck_o <= 1'b0;
                div   <= '0;
                if (avail) begin
                    stall      <= 1'b0;
                    tdi_o      <= word[bit_idx];
                    tms_o      <= (shift_left == LEN_W'(1));
                    shift_left <= shift_left - 1'b1;
                    if (bit_idx == IDX_LAST || shift_left == LEN_W'(1)) begin
                        full    <= 1'b0;
                        bit_idx <= '0;
                    end else begin
                        full    <= 1'b1;
                        hold    <= word;
                        bit_idx <= bit_idx + 1'b1;
                    end
                end else begin
                    stall <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtag_tap_master.sv
// Self-checking bench for jtag_tap_master. A reference model derived from the TAP
// walk (expected TMS/TDI per TCK edge, expected dout words) is compared with what
// the DUT drives; TDO is either looped from TDI or a random bit per TCK edge.
module tb_jtag_tap_master;
    localparam int IR_W    = 6;
    localparam int LEN_W   = 16;
    localparam int DATA_W  = 8;
    localparam int TCK_DIV = 2;
    localparam int PER     = 2 * TCK_DIV;
    localparam int LIMIT   = 3000;
    localparam int DR0     = IR_W + 8;   // index of first DR shift edge

    logic clk = 1'b0, rst = 1'b1;
    logic cmd_valid = 1'b0, din_valid = 1'b0;
    logic [IR_W-1:0]   cmd_ir = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic [DATA_W-1:0] din = '0;
    logic cmd_ready, din_ready, dout_valid, done, tck, tms, tdi, tdo, tap_rst_n;
    logic [DATA_W-1:0] dout;

    int errors = 0, checks = 0, done_cnt = 0;
    bit loop = 1'b0;
    logic rnd_tdo = 1'b0;
    logic e_tms[$], e_tdi[$], e_tdo[$];
    logic [DATA_W-1:0] dv_q[$], din_words[$];

    jtag_tap_master #(.IR_W(IR_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .TCK_DIV(TCK_DIV)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_ir_i(cmd_ir), .cmd_len_i(cmd_len),
        .din_i(din), .din_valid_i(din_valid), .din_ready_o(din_ready),
        .dout_o(dout), .dout_valid_o(dout_valid), .done_o(done),
        .tck_o(tck), .tms_o(tms), .tdi_o(tdi), .tdo_i(tdo), .tap_rst_no(tap_rst_n)
    );

    always #5 clk = ~clk;

    assign tdo = loop ? tdi : rnd_tdo;

    always @(posedge tck) begin
        e_tms.push_back(tms);
        e_tdi.push_back(tdi);
        e_tdo.push_back(tdo);
    end
    always @(negedge tck) rnd_tdo = 1'($urandom);

    always @(negedge clk) begin
        if (dout_valid) dv_q.push_back(dout);
        if (done) done_cnt++;
    end

    task automatic test_reset();
        int n;
        logic [5:0] pat;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({tck, tms, tdi, tap_rst_n, cmd_ready, din_ready, dout_valid, done} !== 8'b0100_0000)
            $display("FAIL reset_outputs: got %b want 01000000",
                     {tck, tms, tdi, tap_rst_n, cmd_ready, din_ready, dout_valid, done});
        checks++;
        if (dout !== '0) begin errors++; $display("FAIL reset_dout: got %h want 00", dout); end
        if ({tck, tms, tdi, tap_rst_n, cmd_ready, din_ready, dout_valid, done} !== 8'b0100_0000) errors++;
        e_tms.delete(); e_tdi.delete(); e_tdo.delete();
        rst = 1'b0;
        @(posedge clk); #1; n = 1;
        checks++;
        if (tap_rst_n !== 1'b1) begin errors++; $display("FAIL tap_rst_release: got %b want 1", tap_rst_n); end
        while (!cmd_ready && n < LIMIT) begin @(posedge clk); #1; n++; end
        checks++;
        if (n != 6 * PER) begin errors++; $display("FAIL tlr_ready_cycles: got %0d want %0d", n, 6 * PER); end
        pat = '0;
        foreach (e_tms[i]) if (i < 6) pat[5-i] = e_tms[i];
        checks++;
        if (e_tms.size() != 6 || pat !== 6'b111110)
            begin errors++; $display("FAIL tlr_edges: got %0d edges tms %b want 6 edges 111110", e_tms.size(), pat); end
    endtask

    // Runs one command. gap_word >= 0 withholds that din word until the DUT stalls
    // and then for 20 more cycles.
    task automatic run_cmd(input string name, input logic [IR_W-1:0] ir, input int len,
                           input bit lp, input int gap_word, input bit noise);
        int nw, cyc, hs, ne, bad, t, gbad, n0;
        bit got, rdy_at_done, tms0, tdi0, b;
        logic x_tms[$], x_tdi[$];
        logic [DATA_W-1:0] x_out[$], w, wi;
        nw = (len + DATA_W - 1) / DATA_W;
        while (din_words.size() < nw) din_words.push_back(DATA_W'($urandom));
        loop = lp;
        e_tms.delete(); e_tdi.delete(); e_tdo.delete(); dv_q.delete();

        // Reference TAP walk.
        x_tms = '{1, 1, 0, 0}; x_tdi = '{0, 0, 0, 0};
        for (int k = 0; k < IR_W; k++) begin x_tms.push_back(k == IR_W - 1); x_tdi.push_back(ir[k]); end
        x_tms.push_back(1); x_tdi.push_back(0);
        if (len == 0) begin
            x_tms.push_back(0); x_tdi.push_back(0);
        end else begin
            x_tms.push_back(1); x_tdi.push_back(0);
            x_tms.push_back(0); x_tdi.push_back(0);
            x_tms.push_back(0); x_tdi.push_back(0);
            for (int j = 0; j < len; j++) begin
                wi = din_words[j / DATA_W];
                x_tms.push_back(j == len - 1); x_tdi.push_back(wi[j % DATA_W]);
            end
            x_tms.push_back(1); x_tdi.push_back(0);
            x_tms.push_back(0); x_tdi.push_back(0);
        end
        ne = x_tms.size();

        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL %s_idle_ready: got %b want 1", name, cmd_ready); end
        cmd_ir = ir; cmd_len = LEN_W'(len); cmd_valid = 1'b1;
        @(posedge clk); #1;
        if (noise) cmd_ir = ~ir; else cmd_valid = 1'b0;
        cyc = 0; hs = 0; got = 0; rdy_at_done = 0; gbad = 0; t = 0;
        fork
            begin
                while (!got && cyc < LIMIT) begin
                    @(posedge clk); #1; cyc++;
                    if (done) begin got = 1; rdy_at_done = cmd_ready; cmd_valid = 1'b0; end
                end
            end
            begin
                @(negedge clk);
                for (int k = 0; k < nw; k++) begin
                    if (k == gap_word) begin
                        din_valid = 1'b0; t = 0;
                        while (!din_ready && t < LIMIT) begin @(negedge clk); t++; end
                        while (!tck && t < LIMIT) begin @(negedge clk); t++; end
                        while (tck && t < LIMIT) begin @(negedge clk); t++; end
                        n0 = e_tms.size(); tms0 = tms; tdi0 = tdi;
                        repeat (20) begin
                            @(negedge clk);
                            if (tck !== 1'b0 || tms !== tms0 || tdi !== tdi0) gbad++;
                        end
                        checks++;
                        if (gbad != 0 || e_tms.size() != n0 || t >= LIMIT) begin
                            errors++;
                            $display("FAIL %s_stall: bad cycles %0d new edges %0d want 0 and 0", name, gbad, e_tms.size() - n0);
                        end
                    end
                    din_valid = 1'b1; din = din_words[k]; t = 0;
                    while (!din_ready && t < LIMIT) begin @(negedge clk); t++; end
                    if (din_ready) hs++;
                    @(negedge clk);
                end
                din_valid = 1'b0;
            end
        join

        checks++;
        if (!got) begin errors++; $display("FAIL %s_done_timeout: no done in %0d cycles", name, LIMIT); end
        if (gap_word < 0) begin
            checks++;
            if (cyc != ne * PER) begin errors++; $display("FAIL %s_latency: got %0d want %0d", name, cyc, ne * PER); end
        end
        checks++;
        if (rdy_at_done !== 1'b1) begin errors++; $display("FAIL %s_ready_at_done: got %b want 1", name, rdy_at_done); end
        checks++;
        if (e_tms.size() != ne) begin errors++; $display("FAIL %s_edges: got %0d want %0d", name, e_tms.size(), ne); end
        bad = 0;
        for (int i = 0; i < ne && i < e_tms.size(); i++)
            if (e_tms[i] !== x_tms[i] || e_tdi[i] !== x_tdi[i]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL %s_tms_tdi: %0d edges differ, want 0", name, bad); end
        checks++;
        if (hs != nw) begin errors++; $display("FAIL %s_din_handshakes: got %0d want %0d", name, hs, nw); end

        w = '0;
        for (int j = 0; j < len; j++) begin
            if (lp) begin wi = din_words[j / DATA_W]; b = wi[j % DATA_W]; end
            else b = (DR0 + j < e_tdo.size()) ? e_tdo[DR0 + j] : 1'b0;
            w[j % DATA_W] = b;
            if (j % DATA_W == DATA_W - 1 || j == len - 1) begin x_out.push_back(w); w = '0; end
        end
        bad = 0;
        foreach (x_out[i]) if (i >= dv_q.size() || dv_q[i] !== x_out[i]) bad++;
        checks++;
        if (bad != 0 || dv_q.size() != x_out.size()) begin
            errors++;
            $display("FAIL %s_dout: got %0d words (%0d wrong) want %0d words", name, dv_q.size(), bad, x_out.size());
        end
        if (noise) begin
            repeat (12) @(negedge clk);
            checks++;
            if (e_tms.size() != ne || cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s_busy_ignored: edges %0d ready %b want %0d and 1", name, e_tms.size(), cmd_ready, ne);
            end
        end
        din_words.delete();
    endtask

    task automatic test_ir_only();
        run_cmd("ir_only", 6'h2D, 0, 1'b1, -1, 1'b0);
    endtask

    task automatic test_dr_loop();
        din_words = '{8'hA5, 8'h3C};
        run_cmd("dr16", 6'h2D, 16, 1'b1, -1, 1'b0);
        checks++;
        if (dv_q.size() != 2 || dv_q[0] !== 8'hA5 || dv_q[1] !== 8'h3C) begin
            errors++; $display("FAIL dr16_words: got %0d words want A5 3C", dv_q.size());
        end
    endtask

    task automatic test_len9();
        run_cmd("len9", IR_W'($urandom), 9, 1'b0, -1, 1'b0);
        checks++;
        if (dv_q.size() != 2 || (dv_q[1] >> 1) != 0) begin
            errors++; $display("FAIL len9_partial: got %0d words want 2 with upper bits 0", dv_q.size());
        end
    endtask

    task automatic test_stall();
        din_words = '{8'hA5, 8'h3C};
        run_cmd("stall", 6'h2D, 16, 1'b1, 1, 1'b0);
    endtask

    task automatic test_busy();
        run_cmd("busy", IR_W'($urandom), 5, 1'b0, -1, 1'b1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++)
            run_cmd("rand", IR_W'($urandom), int'($urandom_range(1, 40)), 1'($urandom), -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        int t, n, dv0, d0;
        logic [5:0] pat;
        loop = 1'b0;
        e_tms.delete(); e_tdi.delete(); e_tdo.delete(); dv_q.delete();
        @(negedge clk);
        cmd_ir = IR_W'($urandom); cmd_len = 16; cmd_valid = 1'b1;
        din_valid = 1'b1; din = 8'h5A;
        @(posedge clk); #1; cmd_valid = 1'b0;
        t = 0;
        while (e_tms.size() < DR0 + 5 && t < LIMIT) begin @(negedge clk); t++; end
        while (tck && t < LIMIT) begin @(negedge clk); t++; end
        rst = 1'b1;
        dv0 = dv_q.size(); d0 = done_cnt;
        @(posedge clk); #1;
        checks++;
        if (tck !== 1'b0 || tms !== 1'b1 || cmd_ready !== 1'b0 || tap_rst_n !== 1'b0 || t >= LIMIT) begin
            errors++; $display("FAIL mid_reset_outputs: tck %b tms %b ready %b tap_rst_n %b want 0 1 0 0", tck, tms, cmd_ready, tap_rst_n);
        end
        @(negedge clk);
        rst = 1'b0; din_valid = 1'b0;
        e_tms.delete(); e_tdi.delete(); e_tdo.delete();
        n = 0;
        while (!cmd_ready && n < LIMIT) begin @(posedge clk); #1; n++; end
        checks++;
        if (n != 6 * PER) begin errors++; $display("FAIL mid_tlr_cycles: got %0d want %0d", n, 6 * PER); end
        pat = '0;
        foreach (e_tms[i]) if (i < 6) pat[5-i] = e_tms[i];
        checks++;
        if (e_tms.size() != 6 || pat !== 6'b111110)
            begin errors++; $display("FAIL mid_tlr_edges: got %0d edges tms %b want 6 edges 111110", e_tms.size(), pat); end
        checks++;
        if (dv_q.size() != dv0 || done_cnt != d0) begin
            errors++; $display("FAIL mid_no_strobes: dout %0d done %0d new strobes want 0 0", dv_q.size() - dv0, done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_ir_only();
        test_dr_loop();
        test_len9();
        test_stall();
        test_busy();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
